alu_sequencer: RTL and testbench

FSM front-end that sequences operand/opcode entry and execution for the board-level 8-bit ALU. It replaces the four independent active-low load buttons with two buttons, "next" and "back". Both buttons are synchronised and debounced. The block walks the user through A -> B -> opcode -> execute -> show, drives the ALU operand inputs, waits a settle time and latches the ALU output into a result register for the 7-segment decoders.

---
 rtl/alu_sequencer.sv | 176 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Two-button front-end for the board ALU: walks the user through A -> B -> opcode -> execute -> show,
// holds the operands steady while the ALU settles, then latches its output for the displays.
module alu_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int EXEC_WAIT       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       btn_next_n,
    input  logic       btn_back_n,
    input  logic [7:0] alu_result,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic [3:0] op_code,
    output logic [7:0] result,
    output logic [2:0] state,
    output logic       result_valid,
    output logic       busy
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int EX_W = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    // Button index 0 is "next", index 1 is "back"; all button levels are active-low.
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      db_q, db_d;
    logic [1:0]      press_q, press_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    state_t          state_q, state_d;
    logic [7:0]      op_a_q, op_a_d;
    logic [7:0]      op_b_q, op_b_d;
    logic [3:0]      op_code_q, op_code_d;
    logic [7:0]      result_q, result_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic [EX_W-1:0] ex_cnt_q, ex_cnt_d;

    logic            next_ev;
    logic            back_ev;

    always_comb begin
        sync1_d = {btn_back_n, btn_next_n};
        sync2_d = sync1_q;
        for (int i = 0; i < 2; i++) begin
            db_d[i]     = db_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i]     = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end else begin
                db_cnt_d[i] = '0;
            end
            // Only the debounced 1->0 edge is an event; release is silent.
            press_d[i] = db_q[i] & ~db_d[i];
        end
    end

    // Coincident presses cancel each other.
    assign next_ev = press_q[0] & ~press_q[1];
    assign back_ev = press_q[1] & ~press_q[0];

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_code_d = op_code_q;
        result_d  = result_q;
        valid_d   = valid_q;
        ex_cnt_d  = ex_cnt_q;
        case (state_q)
            S_A: begin
                if (next_ev) begin
                    op_a_d  = sw;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (next_ev) begin
                    op_b_d  = sw;
                    state_d = S_OP;
                end else if (back_ev) begin
                    state_d = S_A;
                end
            end
            S_OP: begin
                if (next_ev) begin
                    op_code_d = sw[3:0];
                    valid_d   = 1'b0;
                    ex_cnt_d  = '0;
                    state_d   = S_EXEC;
                end else if (back_ev) begin
                    state_d = S_B;
                end
            end
            S_EXEC: begin
                // Buttons are deliberately ignored here so the ALU inputs stay put.
                if (ex_cnt_q == EX_W'(EXEC_WAIT - 1)) begin
                    result_d = alu_result;
                    valid_d  = 1'b1;
                    ex_cnt_d = '0;
                    state_d  = S_SHOW;
                end else begin
                    ex_cnt_d = ex_cnt_q + EX_W'(1);
                end
            end
            S_SHOW: begin
                if (next_ev) begin
                    state_d = S_A;
                end else if (back_ev) begin
                    state_d = S_OP;
                end
            end
            default: state_d = S_A;
        endcase
        busy_d = (state_d == S_EXEC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            db_q        <= 2'b11;
            press_q     <= 2'b00;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            state_q     <= S_A;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_code_q   <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            ex_cnt_q    <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            press_q     <= press_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_code_q   <= op_code_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            ex_cnt_q    <= ex_cnt_d;
        end
    end

    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign op_code      = op_code_q;
    assign result       = result_q;
    assign state        = state_q;
    assign result_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a short debounce and a two-cycle execute window;
// the ALU is modelled as A+B for opcode 0 and A-B otherwise.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic       btn_next_n;
    logic       btn_back_n;
    logic [7:0] alu_result;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] op_code;
    logic [7:0] result;
    logic [2:0] state;
    logic       result_valid;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int busy_cnt = 0;
    int valid_in_exec = 0;

    alu_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .EXEC_WAIT      (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .btn_next_n  (btn_next_n),
        .btn_back_n  (btn_back_n),
        .alu_result  (alu_result),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_code     (op_code),
        .result      (result),
        .state       (state),
        .result_valid(result_valid),
        .busy        (busy)
    );

    assign alu_result = (op_code == 4'd0) ? (op_a + op_b) : (op_a - op_b);

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy) begin
            busy_cnt++;
            if (result_valid) valid_in_exec++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold long enough for the debounced press, then long enough for the release to settle.
    task automatic press(input logic nxt, input logic bck);
        btn_next_n = ~nxt;
        btn_back_n = ~bck;
        tick(10);
        btn_next_n = 1'b1;
        btn_back_n = 1'b1;
        tick(10);
    endtask

    initial begin
        rst        = 1'b1;
        sw         = 8'h00;
        btn_next_n = 1'b1;
        btn_back_n = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_state", {5'd0, state}, 8'd0);
        check("rst_op_a", op_a, 8'h00);
        check("rst_valid", {7'd0, result_valid}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);

        // Press latency: drop in cycle t, pulse in cycle t+6, state moves one edge later.
        sw = 8'h05;
        btn_next_n = 1'b0;
        tick(6);
        check("press_not_early", {5'd0, state}, 8'd0);
        tick(1);
        check("press_latency", {5'd0, state}, 8'd1);
        check("latch_a", op_a, 8'h05);
        tick(100);
        check("held_no_repeat", {5'd0, state}, 8'd1);
        btn_next_n = 1'b1;
        tick(10);

        // Three-cycle glitch must not register.
        sw = 8'h77;
        btn_next_n = 1'b0;
        tick(3);
        btn_next_n = 1'b1;
        tick(12);
        check("glitch_state", {5'd0, state}, 8'd1);
        check("glitch_op_b", op_b, 8'h00);

        sw = 8'h03;
        press(1'b1, 1'b0);
        check("latch_b_state", {5'd0, state}, 8'd2);
        check("latch_b", op_b, 8'h03);

        sw = 8'h00;
        busy_cnt = 0;
        press(1'b1, 1'b0);
        check("exec1_busy_cycles", busy_cnt[7:0], 8'd2);
        check("exec1_state", {5'd0, state}, 8'd4);
        check("exec1_result", result, 8'h08);
        check("exec1_valid", {7'd0, result_valid}, 8'd1);
        check("exec1_op_code", {4'd0, op_code}, 8'd0);

        // Show -> back -> opcode again with same operands.
        press(1'b0, 1'b1);
        check("show_back_state", {5'd0, state}, 8'd2);
        sw = 8'h01;
        busy_cnt = 0;
        valid_in_exec = 0;
        press(1'b1, 1'b0);
        check("exec2_busy_cycles", busy_cnt[7:0], 8'd2);
        check("exec2_valid_low_in_exec", valid_in_exec[7:0], 8'd0);
        check("exec2_op_code", {4'd0, op_code}, 8'd1);
        check("exec2_result", result, 8'h02);
        check("exec2_valid", {7'd0, result_valid}, 8'd1);
        check("exec2_op_a", op_a, 8'h05);

        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        check("op_back_state", {5'd0, state}, 8'd1);
        check("op_back_op_a", op_a, 8'h05);
        check("op_back_op_b", op_b, 8'h03);

        sw = 8'h99;
        press(1'b1, 1'b1);
        check("simul_state", {5'd0, state}, 8'd1);
        check("simul_op_b", op_b, 8'h03);

        press(1'b0, 1'b1);
        check("b_back_state", {5'd0, state}, 8'd0);
        press(1'b0, 1'b1);
        check("a_back_ignored", {5'd0, state}, 8'd0);
        check("a_back_op_a", op_a, 8'h05);

        // Wrap case, with a back press landing inside EXEC.
        sw = 8'hFF;
        press(1'b1, 1'b0);
        sw = 8'h01;
        press(1'b1, 1'b0);
        sw = 8'h00;
        btn_next_n = 1'b0;
        tick(1);
        btn_back_n = 1'b0;
        tick(6);
        check("lockout_exec_entry", {5'd0, state}, 8'd3);
        tick(1);
        check("lockout_exec_hold", {5'd0, state}, 8'd3);
        tick(1);
        check("lockout_show", {5'd0, state}, 8'd4);
        check("wrap_result", result, 8'h00);
        check("wrap_valid", {7'd0, result_valid}, 8'd1);
        tick(10);
        check("lockout_not_queued", {5'd0, state}, 8'd4);
        btn_next_n = 1'b1;
        btn_back_n = 1'b1;
        tick(10);

        press(1'b1, 1'b0);
        check("show_next_state", {5'd0, state}, 8'd0);
        check("show_next_result", result, 8'h00);
        check("show_next_valid", {7'd0, result_valid}, 8'd1);

        // A-operand overwrite leaves result_valid alone.
        sw = 8'h12;
        press(1'b1, 1'b0);
        check("overwrite_valid", {7'd0, result_valid}, 8'd1);
        sw = 8'h34;
        press(1'b1, 1'b0);
        check("pre_reset_state", {5'd0, state}, 8'd2);
        check("pre_reset_op_a", op_a, 8'h12);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_state", {5'd0, state}, 8'd0);
        check("mid_rst_op_a", op_a, 8'h00);
        check("mid_rst_op_b", op_b, 8'h00);
        check("mid_rst_op_code", {4'd0, op_code}, 8'd0);
        check("mid_rst_result", result, 8'h00);
        check("mid_rst_valid", {7'd0, result_valid}, 8'd0);
        check("mid_rst_busy", {7'd0, busy}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
